// File: rtl/sine_frame_scheduler.sv
// sine_frame_scheduler
//   Runs one sine-sample frame per accepted tick: reads the word from the sine ROM,
//   hands its high byte and then its low byte to the serial shift register, and
//   finishes by pulsing soc to the DAC. Ticks that arrive mid-frame are dropped and
//   flagged on the sticky overrun output.
//   Optional feature macro: SINE_SCHED_STEP_EN adds the step input (programmable
//   address increment); without it the address advances by 1 per frame.
// Ports
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   en, tick            tick request and its enable (en only gates new ticks)
//   overrun_clr         clears the sticky overrun flag (a same-cycle set wins)
//   rom_data            ROM word; [15:8] goes out first, then [7:0]
//   step                address increment, sampled in the SOC cycle (feature only)
//   rom_addr, rom_en    ROM address (current sample index) and one-cycle read strobe
//   sr_pdata, sr_load   parallel byte and one-cycle load strobe for the shift register
//   soc                 one-cycle start-of-conversion pulse at frame end
//   busy, overrun       frame in progress / sticky dropped-tick flag
module sine_frame_scheduler #(
  parameter int unsigned ADDR_W    = 6,
  parameter int unsigned ROM_LAT   = 1,
  parameter int unsigned SHIFT_LEN = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              tick,
  input  logic              overrun_clr,
  input  logic [15:0]       rom_data,
`ifdef SINE_SCHED_STEP_EN
  input  logic [ADDR_W-1:0] step,
`endif
  output logic [ADDR_W-1:0] rom_addr,
  output logic              rom_en,
  output logic [7:0]        sr_pdata,
  output logic              sr_load,
  output logic              soc,
  output logic              busy,
  output logic              overrun
);

  // One counter serves both the ROM wait and the two shift phases.
  localparam int unsigned CntMax = (ROM_LAT > SHIFT_LEN) ? ROM_LAT : SHIFT_LEN;
  localparam int unsigned CntW   = (CntMax > 1) ? $clog2(CntMax) : 1;

  typedef enum logic [2:0] {
    StIdle, StFetch, StWait, StLoadHi, StShiftHi, StLoadLo, StShiftLo, StSoc
  } state_t;

  state_t            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q;
  logic [15:0]       sample_q;
  logic              ovr_q;
  logic              cnt_zero;
  logic [ADDR_W-1:0] addr_inc;

  assign cnt_zero = (cnt_q == '0);

`ifdef SINE_SCHED_STEP_EN
  assign addr_inc = step;
`else
  assign addr_inc = ADDR_W'(1);
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    if (tick && en) state_d = StFetch;
      StFetch:   state_d = StWait;
      StWait:    if (cnt_zero) state_d = StLoadHi;
      StLoadHi:  state_d = StShiftHi;
      StShiftHi: if (cnt_zero) state_d = StLoadLo;
      StLoadLo:  state_d = StShiftLo;
      StShiftLo: if (cnt_zero) state_d = StSoc;
      StSoc:     state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  // Outputs decoded from the state register only
  always_comb begin
    rom_en   = (state_q == StFetch);
    sr_load  = (state_q == StLoadHi) || (state_q == StLoadLo);
    soc      = (state_q == StSoc);
    busy     = (state_q != StIdle);
    // High byte only while it is being loaded/shifted; otherwise the last low byte holds.
    sr_pdata = ((state_q == StLoadHi) || (state_q == StShiftHi)) ? sample_q[15:8]
                                                                 : sample_q[7:0];
    rom_addr = addr_q;
    overrun  = ovr_q;
  end

  // Phase counter: preloaded in the cycle before each timed phase, counts down to 0.
  always_comb begin
    cnt_d = cnt_q;
    if (state_q == StFetch) begin
      cnt_d = CntW'(ROM_LAT - 1);
    end else if ((state_q == StLoadHi) || (state_q == StLoadLo)) begin
      cnt_d = CntW'(SHIFT_LEN - 1);
    end else if (!cnt_zero) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      addr_q   <= '0;
      sample_q <= '0;
      ovr_q    <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      // ROM word is valid on the last WAIT cycle.
      if ((state_q == StWait) && cnt_zero) sample_q <= rom_data;
      if (state_q == StSoc) addr_q <= addr_q + addr_inc;
      if (tick && en && (state_q != StIdle)) begin
        ovr_q <= 1'b1;
      end else if (overrun_clr) begin
        ovr_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sine_frame_scheduler.sv
module tb_sine_frame_scheduler;
  localparam int AW     = 6;
  localparam int LAT    = 1;
  localparam int SL     = 8;
  localparam int OffHi  = 2 + LAT;
  localparam int OffLo  = 3 + LAT + SL;
  localparam int OffSoc = 4 + LAT + 2 * SL;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          en = 1'b0;
  logic          tick = 1'b0;
  logic          overrun_clr = 1'b0;
  logic [15:0]   rom_data = '0;
  logic [AW-1:0] rom_addr;
  logic          rom_en, sr_load, soc, busy, overrun;
  logic [7:0]    sr_pdata;
`ifdef SINE_SCHED_STEP_EN
  logic [AW-1:0] step = '0;
`endif

  sine_frame_scheduler #(.ADDR_W(AW), .ROM_LAT(LAT), .SHIFT_LEN(SL)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .tick(tick), .overrun_clr(overrun_clr),
    .rom_data(rom_data),
`ifdef SINE_SCHED_STEP_EN
    .step(step),
`endif
    .rom_addr(rom_addr), .rom_en(rom_en), .sr_pdata(sr_pdata), .sr_load(sr_load),
    .soc(soc), .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Sine ROM model with one cycle of read latency.
  logic [15:0] mem [64];
  always @(posedge clk) if (rom_en) rom_data <= mem[rom_addr];

  typedef struct packed { int c; int v; } ev_t;
  ev_t fetch_q[$], load_q[$], soc_q[$], st_q[$];

  int n_tests = 0;
  int n_fail  = 0;
  bit mon_on  = 1'b0;
  bit auto_tick = 1'b0;

  task automatic check(input string nm, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", nm, cyc, act, exp);
    end
  endtask

  task automatic pop_ev(ref ev_t q[$], input string nm, input int val);
    ev_t e;
    if (q.size() == 0) begin
      check({"unexpected ", nm}, 1, 0);
    end else begin
      e = q.pop_front();
      check({nm, " cycle"}, cyc, e.c);
      check({nm, " value"}, val, e.v);
    end
  endtask

  task automatic drop_stale(ref ev_t q[$], input string nm);
    while (q.size() > 0 && q[0].c < cyc) begin
      check({"missing ", nm}, cyc, q[0].c);
      void'(q.pop_front());
    end
  endtask

  // Monitor: compares whatever the DUT presents against the scoreboard queues.
  always @(negedge clk) begin
    if (rst_n && mon_on) begin
      if (rom_en)  pop_ev(fetch_q, "fetch", int'(rom_addr));
      if (sr_load) pop_ev(load_q, "load", int'(sr_pdata));
      if (soc)     pop_ev(soc_q, "soc", int'(rom_addr));
      drop_stale(fetch_q, "fetch");
      drop_stale(load_q, "load");
      drop_stale(soc_q, "soc");
      while (st_q.size() > 0 && st_q[0].c <= cyc) begin
        if (st_q[0].c == cyc) begin
          check("busy", int'(busy), st_q[0].v[1]);
          check("overrun", int'(overrun), st_q[0].v[0]);
        end
        void'(st_q.pop_front());
      end
    end
  end

  // Reference model: frame-level bookkeeping only.
  int m_soc  = -100;  // SOC cycle of the current/last accepted frame
  int m_addr = 0;
  bit m_ovr  = 1'b0;

  task automatic drive(input bit t, input bit e, input bit c);
    int  T;
    int  inc;
    bit  busy_now;
    @(negedge clk);
    T = cyc;
    busy_now = (T <= m_soc);
    if (auto_tick) t = !busy_now;
    tick = t; en = e; overrun_clr = c;
    inc = 1;
`ifdef SINE_SCHED_STEP_EN
    step = AW'($urandom);
    inc = int'(step);
`endif
    if (T == m_soc) m_addr = (m_addr + inc) % (1 << AW);
    if (t && e && !busy_now) begin
      fetch_q.push_back('{T + 1, m_addr});
      load_q.push_back('{T + OffHi, int'(mem[m_addr][15:8])});
      load_q.push_back('{T + OffLo, int'(mem[m_addr][7:0])});
      soc_q.push_back('{T + OffSoc, m_addr});
      m_soc = T + OffSoc;
    end
    if (t && e && busy_now) m_ovr = 1'b1;
    else if (c) m_ovr = 1'b0;
    st_q.push_back('{T + 1, {30'd0, (T + 1 <= m_soc), m_ovr}});
  endtask

  task automatic check_reset_outputs();
    check("rst busy", int'(busy), 0);
    check("rst rom_en", int'(rom_en), 0);
    check("rst sr_load", int'(sr_load), 0);
    check("rst soc", int'(soc), 0);
    check("rst overrun", int'(overrun), 0);
    check("rst rom_addr", int'(rom_addr), 0);
    check("rst sr_pdata", int'(sr_pdata), 0);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 16'($urandom);
    mem[0] = 16'hA55A;
    repeat (3) @(negedge clk);
    check_reset_outputs();
    rst_n = 1'b1;
    mon_on = 1'b1;

    // Single frame from address 0.
    for (int i = 0; i < 26; i++) drive(i == 0, 1'b1, 1'b0);
    // Overrun tick at c10, then clear together with a busy tick, then clear alone.
    for (int i = 0; i < 26; i++) drive(i == 0 || i == 10 || i == 12, 1'b1, i == 12 || i == 14);
    // Tick with en low is ignored; a frame whose en drops at c5 still completes.
    for (int i = 0; i < 4; i++) drive(i == 1, 1'b0, 1'b0);
    for (int i = 0; i < 26; i++) drive(i == 0, i < 5, 1'b0);

    // Asynchronous reset in SHIFT_HI.
    drive(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 7; i++) drive(1'b0, 1'b1, 1'b0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    tick = 1'b0;
    #1 check_reset_outputs();
    fetch_q.delete(); load_q.delete(); soc_q.delete(); st_q.delete();
    m_soc = -100; m_addr = 0; m_ovr = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b1;
    for (int i = 0; i < 26; i++) drive(i == 0, 1'b1, 1'b0);

    // Back-to-back frames across the address wrap.
    auto_tick = 1'b1;
    for (int i = 0; i < 66 * (OffSoc + 1); i++) drive(1'b0, 1'b1, 1'b0);
    auto_tick = 1'b0;

    // Random traffic.
    for (int i = 0; i < 4000; i++)
      drive($urandom_range(3) == 0, $urandom_range(7) != 0, $urandom_range(15) == 0);
    for (int i = 0; i < 40; i++) drive(1'b0, 1'b1, 1'b0);

    check("pending events", fetch_q.size() + load_q.size() + soc_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
